xilinx_phy10g_rx_reset_seq: RTL and testbench

Per-lane RX-side reset sequencer for the 10G PHY. It is the receive-direction counterpart of the shared TX reset and userrdy logic. It holds the GT RX in reset until the QPLL is locked, then releases it. It then waits for the GT to report reset done, asserts rxuserrdy, and qualifies the link on PCS block lock. Each wait stage has a timeout that restarts the sequence, and loss of lock is debounced before the sequence restarts.

---
 rtl/xilinx_phy10g_rx_reset_seq.sv | 188 ++++++++++++++++++
 tb/tb_xilinx_phy10g_rx_reset_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_phy10g_rx_reset_seq.sv
// Per-lane RX reset sequencer for the 10G PHY: holds the GT RX in reset until
// the QPLL locks, pulses gtrxreset, waits for rxresetdone, raises rxuserrdy and
// qualifies the link on PCS block lock. Every wait stage can time out and
// restart the sequence; loss of block lock is filtered before restarting.
// Optional feature: define XILINX_PHY10G_RX_RETRY_CNT_EN to add retry_cnt_o,
// a saturating count of timeout and lock-loss restarts.
module xilinx_phy10g_rx_reset_seq #(
    parameter int unsigned SYNC_REGS         = 4,
    parameter int unsigned HOLD_CYCLES       = 16,
    parameter int unsigned RESETDONE_TIMEOUT = 65535,
    parameter int unsigned LOCK_TIMEOUT      = 156250,
    parameter int unsigned LOSS_FILTER       = 8,
    parameter int unsigned CNT_W             = 18
) (
    input  logic       clk156,
    input  logic       gttxreset_txusrclk2,
    input  logic       qplllock_i,
    input  logic       rxresetdone_i,
    input  logic       block_lock_i,
    output logic       gtrxreset_o,
    output logic       rxuserrdy_o,
    output logic       rxpcsreset_o,
    output logic       rx_ready_o,
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
    output logic [7:0] retry_cnt_o,
`endif
    output logic [2:0] state_o
);

    localparam int unsigned LOSS_W = $clog2(LOSS_FILTER + 1);

    typedef enum logic [2:0] {
        S_WAIT_QPLL = 3'd0,
        S_HOLD      = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_USERRDY   = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_READY     = 3'd5
    } state_t;

    logic [SYNC_REGS-1:0] r_qpll_sync;
    logic [SYNC_REGS-1:0] r_done_sync;
    logic [SYNC_REGS-1:0] r_lock_sync;
    state_t               r_state;
    logic [CNT_W-1:0]     r_timer;
    logic [LOSS_W-1:0]    r_loss;
    // {gtrxreset, rxpcsreset, rxuserrdy, rx_ready}
    logic [3:0]           r_outs;

    logic w_qpll;
    logic w_done;
    logic w_lock;
    logic w_abort;
    logic w_done_tmo;
    logic w_lock_tmo;
    logic w_loss_trip;
    logic w_restart;

    // Output levels belonging to each state, registered on state entry
    function automatic logic [3:0] f_outs(input state_t s);
        case (s)
            S_WAIT_DONE:            return 4'b0100;
            S_USERRDY, S_WAIT_LOCK: return 4'b0010;
            S_READY:                return 4'b0011;
            default:                return 4'b1100;
        endcase
    endfunction

    // Input synchronisers; the last stage feeds all decisions
    always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
        if (gttxreset_txusrclk2) begin
            r_qpll_sync <= '0;
            r_done_sync <= '0;
            r_lock_sync <= '0;
        end else begin
            r_qpll_sync <= {r_qpll_sync[SYNC_REGS-2:0], qplllock_i};
            r_done_sync <= {r_done_sync[SYNC_REGS-2:0], rxresetdone_i};
            r_lock_sync <= {r_lock_sync[SYNC_REGS-2:0], block_lock_i};
        end
    end

    assign w_qpll = r_qpll_sync[SYNC_REGS-1];
    assign w_done = r_done_sync[SYNC_REGS-1];
    assign w_lock = r_lock_sync[SYNC_REGS-1];

    // QPLL loss overrides everything; retries only when not aborting
    assign w_abort     = (r_state != S_WAIT_QPLL) && !w_qpll;
    assign w_done_tmo  = (r_state == S_WAIT_DONE) && !w_done
                         && (r_timer == CNT_W'(RESETDONE_TIMEOUT - 1));
    assign w_lock_tmo  = (r_state == S_WAIT_LOCK) && !w_lock
                         && (r_timer == CNT_W'(LOCK_TIMEOUT - 1));
    assign w_loss_trip = (r_state == S_READY) && !w_lock
                         && (r_loss == LOSS_W'(LOSS_FILTER - 1));
    assign w_restart   = !w_abort && (w_done_tmo || w_lock_tmo || w_loss_trip);

    // Sequencer: state, stage timer, loss filter and registered outputs
    always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
        if (gttxreset_txusrclk2) begin
            r_state <= S_WAIT_QPLL;
            r_outs  <= 4'b1100;
            r_timer <= '0;
            r_loss  <= '0;
        end else if (w_abort || w_restart) begin
            r_state <= S_WAIT_QPLL;
            r_outs  <= f_outs(S_WAIT_QPLL);
            r_timer <= '0;
            r_loss  <= '0;
        end else begin
            case (r_state)
                S_WAIT_QPLL: begin
                    if (w_qpll) begin
                        r_state <= S_HOLD;
                        r_outs  <= f_outs(S_HOLD);
                        r_timer <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_timer == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_state <= S_WAIT_DONE;
                        r_outs  <= f_outs(S_WAIT_DONE);
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (w_done) begin
                        r_state <= S_USERRDY;
                        r_outs  <= f_outs(S_USERRDY);
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                S_USERRDY: begin
                    r_state <= S_WAIT_LOCK;
                    r_outs  <= f_outs(S_WAIT_LOCK);
                    r_timer <= '0;
                end
                S_WAIT_LOCK: begin
                    if (w_lock) begin
                        r_state <= S_READY;
                        r_outs  <= f_outs(S_READY);
                        r_timer <= '0;
                        r_loss  <= '0;
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end
                S_READY: begin
                    if (w_lock) begin
                        r_loss <= '0;
                    end else begin
                        r_loss <= r_loss + LOSS_W'(1);
                    end
                end
                default: begin
                    r_state <= S_WAIT_QPLL;
                    r_outs  <= f_outs(S_WAIT_QPLL);
                    r_timer <= '0;
                    r_loss  <= '0;
                end
            endcase
        end
    end

`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
    logic [7:0] r_retry_cnt;

    // Saturating count of timeout and lock-loss restarts
    always_ff @(posedge clk156 or posedge gttxreset_txusrclk2) begin
        if (gttxreset_txusrclk2) begin
            r_retry_cnt <= '0;
        end else if (w_restart && (r_retry_cnt != 8'hFF)) begin
            r_retry_cnt <= r_retry_cnt + 8'd1;
        end
    end

    assign retry_cnt_o = r_retry_cnt;
`endif

    assign gtrxreset_o  = r_outs[3];
    assign rxpcsreset_o = r_outs[2];
    assign rxuserrdy_o  = r_outs[1];
    assign rx_ready_o   = r_outs[0];
    assign state_o      = r_state;

endmodule

// File: tb/tb_xilinx_phy10g_rx_reset_seq.sv
// Bench for the RX reset sequencer: directed scenarios plus random input
// toggling, every cycle compared against a phase/age reference model.
module tb_xilinx_phy10g_rx_reset_seq;

    localparam int unsigned SYNC_REGS = 2;
    localparam int unsigned HOLD      = 4;
    localparam int unsigned RD_TMO    = 20;
    localparam int unsigned LK_TMO    = 30;
    localparam int unsigned LOSS      = 3;

    // Phases of the bring-up sequence (numbered as state_o reports them)
    localparam int P_WQ = 0, P_HOLD = 1, P_WD = 2, P_UR = 3, P_WL = 4, P_RDY = 5;

    logic       clk156 = 1'b0;
    logic       tb_rst;
    logic       tb_qpll;
    logic       tb_done;
    logic       tb_lock;
    logic       gtrxreset_o;
    logic       rxuserrdy_o;
    logic       rxpcsreset_o;
    logic       rx_ready_o;
    logic [2:0] state_o;
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
    logic [7:0] retry_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    xilinx_phy10g_rx_reset_seq #(
        .SYNC_REGS        (SYNC_REGS),
        .HOLD_CYCLES      (HOLD),
        .RESETDONE_TIMEOUT(RD_TMO),
        .LOCK_TIMEOUT     (LK_TMO),
        .LOSS_FILTER      (LOSS),
        .CNT_W            (18)
    ) u_dut (
        .clk156             (clk156),
        .gttxreset_txusrclk2(tb_rst),
        .qplllock_i         (tb_qpll),
        .rxresetdone_i      (tb_done),
        .block_lock_i       (tb_lock),
        .gtrxreset_o        (gtrxreset_o),
        .rxuserrdy_o        (rxuserrdy_o),
        .rxpcsreset_o       (rxpcsreset_o),
        .rx_ready_o         (rx_ready_o),
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        .retry_cnt_o        (retry_cnt_o),
`endif
        .state_o            (state_o)
    );

    always #5 clk156 = ~clk156;

    // Reference model: current phase, edges spent in it, run of low lock samples
    int m_ph, m_age, m_low, m_retry;
    bit q_hist[$];
    bit d_hist[$];
    bit l_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ph = P_WQ; m_age = 0; m_low = 0; m_retry = 0;
        q_hist.delete(); d_hist.delete(); l_hist.delete();
        for (int i = 0; i < int'(SYNC_REGS); i++) begin
            q_hist.push_back(1'b0); d_hist.push_back(1'b0); l_hist.push_back(1'b0);
        end
    endfunction

    function automatic void enter(input int ph);
        m_ph = ph; m_age = 0; m_low = 0;
    endfunction

    function automatic void restart();
        enter(P_WQ);
        if (m_retry < 255) m_retry++;
    endfunction

    // One clock edge: inputs become visible SYNC_REGS edges after being applied
    function automatic void model_edge();
        bit q, d, l;
        q = q_hist.pop_front(); q_hist.push_back(tb_qpll);
        d = d_hist.pop_front(); d_hist.push_back(tb_done);
        l = l_hist.pop_front(); l_hist.push_back(tb_lock);
        if (m_ph != P_WQ && !q) begin
            enter(P_WQ);
        end else begin
            case (m_ph)
                P_WQ:   if (q) enter(P_HOLD);
                P_HOLD: if (m_age + 1 == int'(HOLD)) enter(P_WD); else m_age++;
                P_WD:   if (d) enter(P_UR);
                        else if (m_age + 1 == int'(RD_TMO)) restart();
                        else m_age++;
                P_UR:   enter(P_WL);
                P_WL:   if (l) enter(P_RDY);
                        else if (m_age + 1 == int'(LK_TMO)) restart();
                        else m_age++;
                P_RDY: begin
                    m_low = l ? 0 : m_low + 1;
                    if (m_low == int'(LOSS)) restart();
                end
                default: enter(P_WQ);
            endcase
        end
    endfunction

    // {phase, gtrxreset, rxpcsreset, rxuserrdy, rx_ready}
    function automatic logic [6:0] exp_outs();
        logic [3:0] o;
        case (m_ph)
            P_WD:       o = 4'b0100;
            P_UR, P_WL: o = 4'b0010;
            P_RDY:      o = 4'b0011;
            default:    o = 4'b1100;
        endcase
        return {3'(m_ph), o};
    endfunction

    function automatic logic [6:0] dut_outs();
        return {state_o, gtrxreset_o, rxpcsreset_o, rxuserrdy_o, rx_ready_o};
    endfunction

    task automatic cycle();
        @(posedge clk156);
        if (tb_rst) model_reset(); else model_edge();
        #1;
        check("outs", 32'(dut_outs()), 32'(exp_outs()));
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        check("retry", 32'(retry_cnt_o), 32'(m_retry));
`endif
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_o !== s && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic count_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (state_o === s && n < budget) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic [2:0] prev;
        logic saw;
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        logic [7:0] retry_keep;
`endif
        tb_rst = 1'b1; tb_qpll = 1'b0; tb_done = 1'b0; tb_lock = 1'b0;
        model_reset();
        repeat (3) cycle();
        check("rst_outs", 32'(dut_outs()), 32'(7'b000_1100));

        // Clean bring-up
        tb_rst = 1'b0; tb_qpll = 1'b1;
        wait_state(3'(P_HOLD), 10, "t1_hold_entry");
        count_state(3'(P_HOLD), 20, n);
        check("t1_hold_len", 32'(n), 32'(HOLD));
        check("t1_gtrx_released", 32'(gtrxreset_o), 32'd0);
        repeat (3) cycle();
        tb_done = 1'b1;
        wait_state(3'(P_UR), 10, "t1_userrdy_entry");
        check("t1_userrdy", 32'({rxuserrdy_o, rxpcsreset_o}), 32'(2'b10));
        repeat (5) cycle();
        tb_lock = 1'b1;
        wait_state(3'(P_RDY), 10, "t1_ready_entry");
        check("t1_ready", 32'(rx_ready_o), 32'd1);

        // Short lock glitch filtered, long one restarts
        tb_lock = 1'b0;
        repeat (2) cycle();
        tb_lock = 1'b1;
        saw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            saw &= rx_ready_o;
        end
        check("t3_glitch_ready", 32'(saw), 32'd1);
        tb_lock = 1'b0;
        repeat (3) cycle();
        tb_lock = 1'b1;
        wait_state(3'(P_WQ), 4, "t3_loss_restart");
        check("t3_ready_drop", 32'(rx_ready_o), 32'd0);

        // QPLL loss during WAIT_LOCK
        tb_lock = 1'b0;
        wait_state(3'(P_WL), 40, "t4_wl_entry");
        repeat (5) cycle();
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        retry_keep = retry_cnt_o;
`endif
        tb_qpll = 1'b0;
        n = 0;
        while (state_o !== 3'(P_WQ) && n < 10) begin
            cycle();
            n++;
        end
        check("t4_abort_latency", 32'(n), 32'(SYNC_REGS + 1));
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        check("t4_retry_kept", 32'(retry_cnt_o), 32'(retry_keep));
`endif
        cycle();
        tb_qpll = 1'b1;

        // Reset-done timeout
        tb_done = 1'b0;
        wait_state(3'(P_WD), 20, "t2_wd_entry");
        count_state(3'(P_WD), 40, n);
        check("t2_wd_len", 32'(n), 32'(RD_TMO));
        check("t2_retry_state", 32'({state_o, gtrxreset_o}), 32'({3'(P_WQ), 1'b1}));

        // Done arriving on the last timeout cycle wins
        wait_state(3'(P_WD), 20, "t2b_wd_entry");
        repeat (int'(RD_TMO) - 3) cycle();
        tb_done = 1'b1;
        repeat (3) cycle();
        check("t2b_done_wins", 32'(state_o), 32'(P_UR));

        // Asynchronous reset in READY
        tb_lock = 1'b1;
        wait_state(3'(P_RDY), 60, "t5_ready_entry");
        cycle();
        #2;
        tb_rst = 1'b1;
        model_reset();
        #1;
        check("t5_async_outs", 32'(dut_outs()), 32'(7'b000_1100));
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        check("t5_async_retry", 32'(retry_cnt_o), 32'd0);
`endif
        repeat (2) cycle();
        tb_rst = 1'b0;
        wait_state(3'(P_HOLD), 10, "t5_restart_hold");
        wait_state(3'(P_RDY), 60, "t5_ready_again");

        // Repeated done timeouts up to saturation
        tb_done = 1'b0;
        tb_rst = 1'b1;
        cycle();
        tb_rst = 1'b0;
        cnt = 0;
        n = 0;
        while (cnt < 20 && n < 20 * 30 + 50) begin
            prev = state_o;
            cycle();
            n++;
            if (prev == 3'(P_WD) && state_o == 3'(P_WQ)) cnt++;
        end
        check("t6_timeouts20", 32'(cnt), 32'd20);
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        check("t6_retry20", 32'(retry_cnt_o), 32'd20);
`endif
        n = 0;
        while (cnt < 300 && n < 280 * 30 + 50) begin
            prev = state_o;
            cycle();
            n++;
            if (prev == 3'(P_WD) && state_o == 3'(P_WQ)) cnt++;
        end
        check("t6_timeouts300", 32'(cnt), 32'd300);
`ifdef XILINX_PHY10G_RX_RETRY_CNT_EN
        check("t6_retry_sat", 32'(retry_cnt_o), 32'd255);
`endif

        // Random input activity
        tb_rst = 1'b1;
        cycle();
        tb_rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) tb_qpll = ~tb_qpll;
            if (!tb_qpll && $urandom_range(0, 3) == 0) tb_qpll = 1'b1;
            if ($urandom_range(0, 11) == 0) tb_done = ~tb_done;
            if ($urandom_range(0, 7) == 0) tb_lock = ~tb_lock;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
